// File: rtl/path_buffer.sv
// Move-history stack with oldest-first replay stream for the maze-solver datapath.
// Define PATH_BUFFER_REVERSE_EN to add replay_rev_i (newest-first, MSB-inverted retrace).
module path_buffer #(
   parameter int unsigned MOVE_W = 2,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [MOVE_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [MOVE_W-1:0] top_data_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              overflow_o,
   input  logic              replay_start_i,
`ifdef PATH_BUFFER_REVERSE_EN
   input  logic              replay_rev_i,
`endif
   output logic              replay_valid_o,
   input  logic              replay_ready_i,
   output logic [MOVE_W-1:0] replay_data_o,
   output logic              replay_done_o,
   output logic              busy_o
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StReplay, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic               overflow_q, overflow_d;
   logic               rev_q, rev_d;
   logic [MOVE_W-1:0]  mem [DEPTH];
   logic               mem_we;
   logic [IdxW-1:0]    mem_waddr;
   logic [IdxW-1:0]    top_idx;
   logic               is_empty, is_full, last_entry, rev_start;
   logic [MOVE_W-1:0]  msb_mask;

`ifdef PATH_BUFFER_REVERSE_EN
   assign rev_start = replay_rev_i;
`else
   assign rev_start = 1'b0;
`endif

   assign msb_mask   = MOVE_W'(1) << (MOVE_W - 1);
   // count == DEPTH wraps to DEPTH-1 in IdxW bits, which is still the top slot
   assign top_idx    = count_q[IdxW-1:0] - IdxW'(1);
   assign is_empty   = (count_q == '0);
   assign is_full    = (count_q == CNT_W'(DEPTH));
   assign last_entry = rev_q ? (idx_q == '0) : (idx_q == top_idx);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      overflow_d = overflow_q;
      rev_d      = rev_q;
      mem_we     = 1'b0;
      mem_waddr  = count_q[IdxW-1:0];
      if (clear_i) begin
         state_d    = StIdle;
         count_d    = '0;
         idx_d      = '0;
         overflow_d = 1'b0;
         rev_d      = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (replay_start_i) begin
                  if (!is_empty) begin
                     state_d = StReplay;
                     rev_d   = rev_start;
                     idx_d   = rev_start ? top_idx : '0;
                  end else begin
                     state_d = StDone;
                  end
               end else if (push_i && pop_i && !is_empty) begin
                  mem_we    = 1'b1;
                  mem_waddr = top_idx;
               end else if (push_i && !is_full) begin
                  mem_we  = 1'b1;
                  count_d = count_q + CNT_W'(1);
               end else if (push_i) begin
                  overflow_d = 1'b1;
               end else if (pop_i && !is_empty) begin
                  count_d = count_q - CNT_W'(1);
               end
            end
            StReplay: begin
               if (replay_ready_i) begin
                  if (last_entry) begin
                     state_d = StDone;
                     idx_d   = '0;
                  end else begin
                     idx_d = rev_q ? idx_q - IdxW'(1) : idx_q + IdxW'(1);
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         count_q    <= '0;
         idx_q      <= '0;
         overflow_q <= 1'b0;
         rev_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
         rev_q      <= rev_d;
      end
   end

   // Storage is not reset; count_q alone defines which entries are live
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[mem_waddr] <= push_data_i;
      end
   end

   assign top_data_o     = is_empty ? '0 : mem[top_idx];
   assign count_o        = count_q;
   assign empty_o        = is_empty;
   assign full_o         = is_full;
   assign overflow_o     = overflow_q;
   assign replay_valid_o = (state_q == StReplay);
   assign replay_data_o  = (state_q == StReplay) ? (mem[idx_q] ^ (rev_q ? msb_mask : '0)) : '0;
   assign replay_done_o  = (state_q == StDone);
   assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_path_buffer.sv
// Directed self-checking bench for path_buffer (DEPTH = 4).
// Define PATH_BUFFER_REVERSE_EN for both files to exercise the retrace replay.
module tb_path_buffer;

   localparam int unsigned MOVE_W = 2;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 3;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              clear_i = 1'b0;
   logic              push_i = 1'b0;
   logic [MOVE_W-1:0] push_data_i = '0;
   logic              pop_i = 1'b0;
   logic [MOVE_W-1:0] top_data_o;
   logic [CNT_W-1:0]  count_o;
   logic              empty_o, full_o, overflow_o;
   logic              replay_start_i = 1'b0;
   logic              replay_rev_i = 1'b0;
   logic              replay_valid_o;
   logic              replay_ready_i = 1'b0;
   logic [MOVE_W-1:0] replay_data_o;
   logic              replay_done_o, busy_o;

   int pass_cnt = 0;
   int check_cnt = 0;

   path_buffer #(.MOVE_W(MOVE_W), .DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .push_i        (push_i),
      .push_data_i   (push_data_i),
      .pop_i         (pop_i),
      .top_data_o    (top_data_o),
      .count_o       (count_o),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .overflow_o    (overflow_o),
      .replay_start_i(replay_start_i),
`ifdef PATH_BUFFER_REVERSE_EN
      .replay_rev_i  (replay_rev_i),
`endif
      .replay_valid_o(replay_valid_o),
      .replay_ready_i(replay_ready_i),
      .replay_data_o (replay_data_o),
      .replay_done_o (replay_done_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Outputs are settled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_push(input logic [MOVE_W-1:0] d);
      push_i = 1'b1;
      push_data_i = d;
      tick();
      push_i = 1'b0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic test_reset();
      push_i = 1'b1;
      push_data_i = 2'd3;
      tick();
      push_i = 1'b0;
      rst_i = 1'b1;
      #2;
      check_cnt++;
      if (count_o !== 3'd0) $display("FAIL reset_count got %0d want 0", count_o);
      else pass_cnt++;
      tick();
      check_cnt++;
      if ({empty_o, full_o, overflow_o, replay_valid_o, replay_done_o, busy_o} !== 6'b100000)
         $display("FAIL reset_flags got %b want 100000",
                  {empty_o, full_o, overflow_o, replay_valid_o, replay_done_o, busy_o});
      else pass_cnt++;
      check_cnt++;
      if ({top_data_o, replay_data_o} !== 4'b0000)
         $display("FAIL reset_data got %b want 0000", {top_data_o, replay_data_o});
      else pass_cnt++;
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_stack();
      do_push(2'd1);
      do_push(2'd2);
      do_push(2'd3);
      check_cnt++;
      if (count_o !== 3'd3 || top_data_o !== 2'd3)
         $display("FAIL push3 got count=%0d top=%0d want count=3 top=3", count_o, top_data_o);
      else pass_cnt++;
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
      check_cnt++;
      if (count_o !== 3'd2 || top_data_o !== 2'd2 || empty_o !== 1'b0)
         $display("FAIL pop got count=%0d top=%0d want count=2 top=2", count_o, top_data_o);
      else pass_cnt++;
      do_clear();
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
      check_cnt++;
      if (count_o !== 3'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || top_data_o !== 2'd0)
         $display("FAIL pop_empty got count=%0d empty=%b ovf=%b want 0 1 0",
                  count_o, empty_o, overflow_o);
      else pass_cnt++;
      // push+pop on empty acts as a push
      push_i = 1'b1;
      pop_i = 1'b1;
      push_data_i = 2'd2;
      tick();
      push_i = 1'b0;
      pop_i = 1'b0;
      check_cnt++;
      if (count_o !== 3'd1 || top_data_o !== 2'd2)
         $display("FAIL pushpop_empty got count=%0d top=%0d want 1 2", count_o, top_data_o);
      else pass_cnt++;
      do_clear();
   endtask

   task automatic test_overflow();
      do_push(2'd1);
      do_push(2'd2);
      do_push(2'd3);
      do_push(2'd1);
      check_cnt++;
      if (full_o !== 1'b1 || overflow_o !== 1'b0)
         $display("FAIL full4 got full=%b ovf=%b want 1 0", full_o, overflow_o);
      else pass_cnt++;
      do_push(2'd2);
      check_cnt++;
      if (full_o !== 1'b1 || count_o !== 3'd4 || overflow_o !== 1'b1 || top_data_o !== 2'd1)
         $display("FAIL overflow got full=%b count=%0d ovf=%b top=%0d want 1 4 1 1",
                  full_o, count_o, overflow_o, top_data_o);
      else pass_cnt++;
      push_i = 1'b1;
      pop_i = 1'b1;
      push_data_i = 2'd0;
      tick();
      push_i = 1'b0;
      pop_i = 1'b0;
      check_cnt++;
      if (count_o !== 3'd4 || top_data_o !== 2'd0 || overflow_o !== 1'b1)
         $display("FAIL replace_full got count=%0d top=%0d ovf=%b want 4 0 1",
                  count_o, top_data_o, overflow_o);
      else pass_cnt++;
      do_clear();
      check_cnt++;
      if (overflow_o !== 1'b0 || count_o !== 3'd0)
         $display("FAIL clear_ovf got ovf=%b count=%0d want 0 0", overflow_o, count_o);
      else pass_cnt++;
   endtask

   // Replay with ready held high; push/pop during replay must be ignored
   task automatic test_replay(input int pass_no);
      int done_seen;
      replay_ready_i = 1'b1;
      replay_start_i = 1'b1;
      pop_i = 1'b1;
      tick();
      replay_start_i = 1'b0;
      done_seen = 0;
      push_i = 1'b1;
      push_data_i = 2'd1;
      for (int i = 0; i < 4; i++) begin
         check_cnt++;
         if (replay_valid_o !== 1'b1 || replay_data_o !== MOVE_W'(i) || busy_o !== 1'b1)
            $display("FAIL replay%0d_beat%0d got valid=%b data=%0d want 1 %0d",
                     pass_no, i, replay_valid_o, replay_data_o, i);
         else pass_cnt++;
         if (replay_done_o) done_seen++;
         tick();
      end
      push_i = 1'b0;
      pop_i = 1'b0;
      check_cnt++;
      if (replay_done_o !== 1'b1 || replay_valid_o !== 1'b0 || busy_o !== 1'b1)
         $display("FAIL replay%0d_done got done=%b valid=%b busy=%b want 1 0 1",
                  pass_no, replay_done_o, replay_valid_o, busy_o);
      else pass_cnt++;
      if (replay_done_o) done_seen++;
      tick();
      if (replay_done_o) done_seen++;
      check_cnt++;
      if (busy_o !== 1'b0 || done_seen != 1 || count_o !== 3'd4)
         $display("FAIL replay%0d_end got busy=%b pulses=%0d count=%0d want 0 1 4",
                  pass_no, busy_o, done_seen, count_o);
      else pass_cnt++;
      replay_ready_i = 1'b0;
   endtask

   task automatic test_ready_toggle();
      int exp_idx;
      int done_seen;
      bit ok;
      replay_start_i = 1'b1;
      tick();
      replay_start_i = 1'b0;
      exp_idx = 0;
      done_seen = 0;
      ok = 1'b1;
      for (int c = 0; c < 20 && done_seen == 0; c++) begin
         if (replay_done_o) begin
            done_seen++;
         end else begin
            if (replay_valid_o !== 1'b1 || replay_data_o !== MOVE_W'(exp_idx)) begin
               ok = 1'b0;
               $display("FAIL toggle_cycle%0d got valid=%b data=%0d want 1 %0d",
                        c, replay_valid_o, replay_data_o, exp_idx);
            end
            replay_ready_i = (c % 2 == 0);
            if (replay_ready_i) exp_idx++;
            tick();
         end
      end
      replay_ready_i = 1'b0;
      check_cnt++;
      if (!ok || exp_idx != 4 || done_seen != 1)
         $display("FAIL toggle_stream got accepted=%0d done=%0d want 4 1", exp_idx, done_seen);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (busy_o !== 1'b0 || replay_done_o !== 1'b0)
         $display("FAIL toggle_idle got busy=%b done=%b want 0 0", busy_o, replay_done_o);
      else pass_cnt++;
   endtask

   task automatic test_empty_clear();
      do_clear();
      replay_start_i = 1'b1;
      tick();
      replay_start_i = 1'b0;
      check_cnt++;
      if (replay_done_o !== 1'b1 || replay_valid_o !== 1'b0)
         $display("FAIL empty_replay got done=%b valid=%b want 1 0", replay_done_o, replay_valid_o);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (busy_o !== 1'b0 || replay_done_o !== 1'b0 || replay_valid_o !== 1'b0)
         $display("FAIL empty_after got busy=%b done=%b want 0 0", busy_o, replay_done_o);
      else pass_cnt++;
      do_push(2'd3);
      do_push(2'd2);
      do_push(2'd1);
      replay_start_i = 1'b1;
      tick();
      replay_start_i = 1'b0;
      tick();
      check_cnt++;
      if (replay_valid_o !== 1'b1 || replay_data_o !== 2'd3)
         $display("FAIL hold got valid=%b data=%0d want 1 3", replay_valid_o, replay_data_o);
      else pass_cnt++;
      replay_ready_i = 1'b1;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check_cnt++;
      if (busy_o !== 1'b0 || count_o !== 3'd0 || replay_done_o !== 1'b0 || replay_valid_o !== 1'b0)
         $display("FAIL clear_replay got busy=%b count=%0d done=%b want 0 0 0",
                  busy_o, count_o, replay_done_o);
      else pass_cnt++;
      tick();
      replay_ready_i = 1'b0;
      check_cnt++;
      if (replay_done_o !== 1'b0 || busy_o !== 1'b0)
         $display("FAIL clear_nodone got done=%b busy=%b want 0 0", replay_done_o, busy_o);
      else pass_cnt++;
   endtask

`ifdef PATH_BUFFER_REVERSE_EN
   task automatic test_reverse();
      logic [MOVE_W-1:0] exp_seq [3];
      exp_seq[0] = 2'd1;
      exp_seq[1] = 2'd3;
      exp_seq[2] = 2'd2;
      do_clear();
      do_push(2'd0);
      do_push(2'd1);
      do_push(2'd3);
      replay_ready_i = 1'b1;
      replay_rev_i = 1'b1;
      replay_start_i = 1'b1;
      tick();
      replay_start_i = 1'b0;
      replay_rev_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_cnt++;
         if (replay_valid_o !== 1'b1 || replay_data_o !== exp_seq[i])
            $display("FAIL reverse_beat%0d got valid=%b data=%0d want 1 %0d",
                     i, replay_valid_o, replay_data_o, exp_seq[i]);
         else pass_cnt++;
         tick();
      end
      check_cnt++;
      if (replay_done_o !== 1'b1)
         $display("FAIL reverse_done got %b want 1", replay_done_o);
      else pass_cnt++;
      replay_ready_i = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_stack();
      test_overflow();
      do_push(2'd0);
      do_push(2'd1);
      do_push(2'd2);
      do_push(2'd3);
      test_replay(1);
      test_replay(2);
      test_ready_toggle();
      test_empty_clear();
`ifdef PATH_BUFFER_REVERSE_EN
      test_reverse();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/path_buffer.md
# path_buffer

Parametrised move-history buffer for the maze-solver datapath. It replaces the fixed 2-bit move queue. During search it acts as a LIFO stack: moves are pushed on advance and popped on backtrack. On command it replays the stored path oldest-first through a valid/ready stream that drives the `move` output of the top level. Contents survive replay, so a found path can be replayed any number of times until cleared.

## Interface
- `MOVE_W`, default 2: width of one move entry.
- `DEPTH`, default 64: maximum stored moves; must be ≥ 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`; derived, not overridden.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `clear`  in  1  synchronous empty; aborts replay.
- `push`  in  1  push `push_data` onto stack.
- `push_data`  in  `MOVE_W`  move to push.
- `pop`  in  1  remove top entry.
- `top_data`  out  `MOVE_W`  current top entry; 0 when empty.
- `count`  out  `CNT_W`  stored entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: push rejected while full.
- `replay_start`  in  1  begin replay (sampled in IDLE only).
- `replay_valid`  out  1  `replay_data` valid.
- `replay_ready`  in  1  consumer accepts the current entry.
- `replay_data`  out  `MOVE_W`  replayed move.
- `replay_done`  out  1  one-cycle pulse at end of replay.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states:
  - IDLE: stack mode, `busy` = 0.
  - REPLAY: streaming entries, `busy` = 1.
  - DONE: one cycle, `replay_done` = 1, then returns to IDLE.
- Transitions:
  - IDLE → REPLAY on `replay_start` when `count > 0`.
  - IDLE → DONE on `replay_start` when `count == 0`; no data is emitted.
- Stack mode (IDLE only):
  - `push` alone with `count < DEPTH`: write `mem[count]`, count+1.
  - `pop` alone with `count > 0`: count−1. Memory contents are not erased.
  - `push` and `pop` together on a non-empty stack: overwrite the top with `push_data`; count unchanged.
  - `push` and `pop` together on an empty stack: behaves as a push.
  - `push` while full (with or without `pop`... with `pop` it is a replace, so it is accepted): with no `pop`, the push is dropped and `overflow` sets.
  - `pop` while empty: ignored, no flag.
  - `replay_start` together with `push` or `pop`: `replay_start` wins; the stack operation is ignored.
- REPLAY:
  - Index `idx` starts at 0. `replay_data = mem[idx]`, `replay_valid = 1`.
  - On `replay_valid & replay_ready`, idx+1.
  - After accepting entry `count−1`, go to DONE.
  - `push`, `pop` and `replay_start` are ignored throughout.
- `clear`, any state: count = 0, idx = 0, `overflow` = 0, FSM → IDLE. No `replay_done` pulse. `clear` has priority over every other input.
- `overflow` clears only on `rst` or `clear`.

## Timing
- Reset values:
  - `count`, `top_data`, `overflow`, `replay_valid`, `replay_data`, `replay_done`, `busy`: 0.
  - `empty`: 1. `full`: 0. FSM: IDLE.
- Reset mid-operation immediately returns the block to the reset values above. Memory contents need not be cleared.
- `count`, `empty`, `full` and `top_data` reflect a push or pop on the next cycle.
- Replay timing:
  - `replay_start` sampled in cycle N → `replay_valid` high in cycle N+1 with `mem[0]`.
  - Throughput is one entry per cycle while `replay_ready` is held high.
  - `replay_data` is stable while `replay_valid & ~replay_ready`.
- Completion: the last acceptance in cycle M gives `replay_done` = 1 in M+1 and `busy` = 0 in M+2.
- An empty replay gives `replay_done` in cycle N+1 with `replay_valid` never asserted.

## Configuration
- `PATH_BUFFER_REVERSE_EN`:
  - When defined: adds input port `replay_rev` (1 bit), sampled with `replay_start`. When `replay_rev` = 1, replay runs newest-first (`mem[count−1]` down to `mem[0]`), giving the retrace path. Each emitted move is XORed with `{1'b1, {MOVE_W-1{1'b0}}}`, i.e. the MSB is inverted. For the 2-bit move encoding this is the opposite direction.
  - When undefined: the port is absent and replay is always oldest-first with data unmodified.

## Test plan
- Reset, push 1,2,3 → `count` = 3, `top_data` = 3. Pop → `count` = 2, `top_data` = 2.
- With DEPTH = 4: push 5 times → `full` = 1, `count` = 4, `overflow` = 1. Pop + push 0 together → `count` = 4, `top_data` = 0.
- Push 0,1,2,3, replay with `replay_ready` tied high → `replay_data` = 0,1,2,3 in consecutive cycles, `replay_done` pulses once. Second replay yields the same sequence.
- Replay with `replay_ready` toggling 1,0,1,0 → each entry is held until accepted, with no loss or duplication.
- `replay_start` while empty → `replay_done` 1 cycle later, `replay_valid` never high. `clear` mid-replay → `busy` drops, `count` = 0, no `replay_done`.
- With `PATH_BUFFER_REVERSE_EN` defined: push 0,1,3, replay with `replay_rev` = 1 → outputs 1,3,2.
